// File: rtl/sound_reg_if_if.sv
// CPU-side register bus for the sound register block: strobes, offset, data in and registered data out.
interface sound_reg_if_if;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic       we;
    logic       re;
    logic [7:0] rdata;

    modport master (output addr, wdata, we, re, input  rdata);
    modport slave  (input  addr, wdata, we, re, output rdata);
endinterface

// File: rtl/sound_reg_if.sv
// Sound register file at 0xFF10-0xFF26: channel registers, NR50-52 power/status,
// trigger pulses and the 512 Hz frame sequencer that paces length/sweep/envelope.
module sound_reg_if (
    input  logic         clock,
    input  logic         reset,
    sound_reg_if_if.slave bus,
    input  logic         div_tick,
    input  logic [3:0]   ch_off,
    output logic [39:0]  ch1_regs,
    output logic [39:0]  ch2_regs,
    output logic [39:0]  ch3_regs,
    output logic [39:0]  ch4_regs,
    output logic [7:0]   nr50,
    output logic [7:0]   nr51,
    output logic [3:0]   trigger,
    output logic         len_tick,
    output logic         sweep_tick,
    output logic         env_tick,
    output logic [3:0]   ch_on
);
    localparam logic [4:0] A_NR52 = 5'h16;

    logic [7:0] regs_q [32];
    logic [7:0] regs_d [32];
    logic       power_q, power_d;
    logic [3:0] ch_on_q, ch_on_d;
    logic [3:0] trig_q, trig_d;
    logic [2:0] step_q, step_d;
    logic [2:0] tick_q, tick_d;
    logic [7:0] rdata_q, rdata_d;

    // NR52 is excluded here; it has its own write and read path.
    function automatic logic is_mapped(input logic [4:0] a);
        return a inside {[5'h00:5'h04], [5'h06:5'h0E], [5'h10:5'h15]};
    endfunction

    function automatic logic [7:0] or_mask(input logic [4:0] a);
        case (a)
            5'h00:                      return 8'h80;
            5'h01, 5'h06:               return 8'h3F;
            5'h02, 5'h07, 5'h11, 5'h12,
            5'h14, 5'h15:               return 8'h00;
            5'h04, 5'h09, 5'h0E, 5'h13: return 8'hBF;
            5'h0A:                      return 8'h7F;
            5'h0C:                      return 8'h9F;
            default:                    return 8'hFF;
        endcase
    endfunction

    always_comb begin
        regs_d  = regs_q;
        power_d = power_q;
        ch_on_d = ch_on_q & ~ch_off;
        trig_d  = '0;
        step_d  = step_q;
        tick_d  = '0;
        rdata_d = rdata_q;

        if (bus.we && bus.addr == A_NR52) begin
            power_d = bus.wdata[7];
        end else if (bus.we && power_q && is_mapped(bus.addr)) begin
            regs_d[bus.addr] = bus.wdata;
            // NRx4 bit 7 is a write-only trigger, never stored
            case (bus.addr)
                5'h04: begin regs_d[bus.addr][7] = 1'b0; trig_d[0] = bus.wdata[7]; end
                5'h09: begin regs_d[bus.addr][7] = 1'b0; trig_d[1] = bus.wdata[7]; end
                5'h0E: begin regs_d[bus.addr][7] = 1'b0; trig_d[2] = bus.wdata[7]; end
                5'h13: begin regs_d[bus.addr][7] = 1'b0; trig_d[3] = bus.wdata[7]; end
                default: ;
            endcase
        end
        ch_on_d = ch_on_d | trig_d;

        if (div_tick && power_q) begin
            tick_d = {~step_q[0], (step_q == 3'd2) || (step_q == 3'd6), step_q == 3'd7};
            step_d = step_q + 3'd1;
        end

        // Powered off: everything but the power bit is held clear.
        if (!power_d) begin
            regs_d  = '{default: '0};
            ch_on_d = '0;
            trig_d  = '0;
            tick_d  = '0;
            step_d  = '0;
        end

        if (bus.re) begin
            if (bus.addr == A_NR52)
                rdata_d = {power_q, 3'b111, ch_on_q};
            else if (is_mapped(bus.addr))
                rdata_d = regs_q[bus.addr] | or_mask(bus.addr);
            else
                rdata_d = 8'hFF;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            regs_q  <= '{default: '0};
            power_q <= 1'b0;
            ch_on_q <= '0;
            trig_q  <= '0;
            step_q  <= '0;
            tick_q  <= '0;
            rdata_q <= '0;
        end else begin
            regs_q  <= regs_d;
            power_q <= power_d;
            ch_on_q <= ch_on_d;
            trig_q  <= trig_d;
            step_q  <= step_d;
            tick_q  <= tick_d;
            rdata_q <= rdata_d;
        end
    end

    assign ch1_regs   = {regs_q[5'h04], regs_q[5'h03], regs_q[5'h02], regs_q[5'h01], regs_q[5'h00]};
    assign ch2_regs   = {regs_q[5'h09], regs_q[5'h08], regs_q[5'h07], regs_q[5'h06], 8'h00};
    assign ch3_regs   = {regs_q[5'h0E], regs_q[5'h0D], regs_q[5'h0C], regs_q[5'h0B], regs_q[5'h0A]};
    assign ch4_regs   = {regs_q[5'h13], regs_q[5'h12], regs_q[5'h11], regs_q[5'h10], 8'h00};
    assign nr50       = regs_q[5'h14];
    assign nr51       = regs_q[5'h15];
    assign trigger    = trig_q;
    assign {len_tick, sweep_tick, env_tick} = tick_q;
    assign ch_on      = ch_on_q;
    assign bus.rdata  = rdata_q;
endmodule

// File: doc/sound_reg_if.md
SOUND_REG_IF -- requirements
Module: sound_reg_if

Interface
REQ-001 SHALL have port: clock  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-003 SHALL have port: addr  input  5  register offset from 0xFF10 (0x00=NR10 ... 0x16=NR52).
REQ-004 SHALL have port: wdata  input  8  write data.
REQ-005 SHALL have port: we  input  1  write strobe, one write per asserted cycle.
REQ-006 SHALL have port: re  input  1  read strobe.
REQ-007 SHALL have port: rdata  output  8  registered read data.
REQ-008 SHALL have port: div_tick  input  1  512 Hz single-cycle enable.
REQ-009 SHALL have port: ch_off  input  4  per-channel length-expiry pulse, bit i = channel i+1.
REQ-010 SHALL have ports: ch1_regs, ch2_regs, ch3_regs, ch4_regs  output  40 each  {NRx4,NRx3,NRx2,NRx1,NRx0}; NRx4 bit 7 always driven 0.
REQ-011 SHALL have ports: nr50, nr51  output  8 each  stored register values.
REQ-012 SHALL have port: trigger  output  4  one-cycle pulse per channel on write of NRx4 bit 7 = 1.
REQ-013 SHALL have ports: len_tick, sweep_tick, env_tick  output  1 each  frame-sequencer enables, one cycle wide.
REQ-014 SHALL have port: ch_on  output  4  channel status, mirrors NR52[3:0].

Function
REQ-015 Write: on we, the addressed register SHALL take wdata on the next rising edge; stored value visible on outputs the following cycle.
REQ-016 Mapped offsets: 0x00-0x04 ch1, 0x06-0x09 ch2 (byte 0 of ch2_regs constant 0), 0x0A-0x0E ch3, 0x10-0x13 ch4 (byte 0 constant 0), 0x14 NR50, 0x15 NR51, 0x16 NR52; all others unmapped: writes ignored, reads 0xFF.
REQ-017 NRx4 write with wdata[7]=1 SHALL store wdata[6:0], keep bit 7 = 0, and assert trigger[i] exactly one cycle after the write edge.
REQ-018 Read: on re, rdata SHALL update on the next edge to (stored value | OR-mask) and hold until the next re; simultaneous re and we to the same offset SHALL return the pre-write value.
REQ-019 OR-masks: NR10 0x80, NR11/NR21 0x3F, NR12/NR22/NR42/NR43/NR50/NR51 0x00, NR13/NR23/NR33/NR31/NR41 0xFF, NR30 0x7F, NR32 0x9F, NRx4 0xBF, NR52 0x70.
REQ-020 NR52: only bit 7 (power) writable; bits 3:0 read ch_on; bits 6:4 read 1.
REQ-021 Power off (NR52[7]=0): all registers except NR52[7] SHALL clear on the write edge; subsequent writes to offsets other than 0x16 ignored; trigger, ticks, ch_on held 0.
REQ-022 ch_on[i]: set on trigger write for channel i; cleared by ch_off[i]; simultaneous trigger write and ch_off[i] -> set wins.
REQ-023 Frame sequencer: 3-bit step, 0 after reset or power-on; on div_tick with step s, next cycle pulse len_tick if s even, sweep_tick if s in {2,6}, env_tick if s==7; step <= (s+1) mod 8, wrapping 7->0.
REQ-024 div_tick while powered off SHALL not advance step.

Reset
REQ-025 On reset: all registers, NR52, step, rdata, trigger, ticks, ch_on SHALL be 0 the cycle after reset is sampled high.
REQ-026 Reset asserted mid-operation SHALL override any concurrent we, re, div_tick or ch_off in that cycle.

Verification
REQ-027 Reset, write NR52=0x80, write NR11=0xC5, read 0x01 -> rdata=0xFF; ch1_regs[15:8]=0xC5.
REQ-028 Write NR14=0xC3 -> trigger=0001 for one cycle, ch1_regs[39:32]=0x43, ch_on=0001; read NR52 -> 0xF1.
REQ-029 ch_on=0001 then ch_off=0001 same cycle as NR14 trigger write -> ch_on stays 0001; ch_off alone next -> 0000.
REQ-030 Eight div_tick pulses from step 0 -> len_tick on steps 0,2,4,6; sweep_tick on 2,6; env_tick on 7; ninth pulse -> len_tick (wrap).
REQ-031 Write NR52=0x00 -> all chX_regs, nr50, nr51 = 0; write NR50=0x77 -> ignored; div_tick -> no ticks; read 0x17 -> 0xFF.
